// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the NITC-RISC24 multi-cycle control unit.
//   - state_e    : one FSM state per datapath clock
//   - OP_*       : opcode field values (Instruction[15:12])
//   - ALU_*      : ALUCtrl operation codes driven to the datapath ALU
//   - CZ_*       : condition field values for conditional R-type instructions
//   - SRCB_*     : ALUSrcB operand selects
//   - strobe_t   : bundle of every datapath control strobe
// Optional feature macro used by the design: MC_INSTRET_EN (retired counter).
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_WB_R   = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_WB_I   = 4'd5,
    ST_MEM_RD = 4'd6,
    ST_MEM_WB = 4'd7,
    ST_MEM_WR = 4'd8,
    ST_BRANCH = 4'd9,
    ST_HALT   = 4'd10
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_ADI  = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // cz = 1x means "never execute"; only the two live encodings are named
  localparam logic [1:0] CZ_ALWAYS  = 2'b00;
  localparam logic [1:0] CZ_IF_ZERO = 2'b01;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       pc_source;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       pc_sel;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
  } strobe_t;

  // The six register-register opcodes occupy a contiguous block
  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOR);
  endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: control <-> datapath bundle.
//   Datapath -> control : Op (Instruction[15:12]), cz (Instruction[1:0]), Zero
//   Control -> datapath : IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource,
//                         ALUSrcA, RegWrite, RegDst, PCSel, ALUSrcB[1:0], ALUCtrl[3:0]
// modport master = control unit, modport slave = datapath.
interface mc_if;
  logic [3:0] Op;
  logic [1:0] cz;
  logic       Zero;

  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       PCSource;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic       PCSel;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUCtrl;

  modport master (
    input  Op, cz, Zero,
    output IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource,
           ALUSrcA, RegWrite, RegDst, PCSel, ALUSrcB, ALUCtrl
  );

  modport slave (
    output Op, cz, Zero,
    input  IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource,
           ALUSrcA, RegWrite, RegDst, PCSel, ALUSrcB, ALUCtrl
  );
endinterface

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: combinational opcode -> ALUCtrl mapping used in EXEC_R.
//   op       in  4 : opcode field
//   alu_ctrl out 4 : ALU operation code
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] alu_ctrl
);

  // Non-R-type opcodes never reach EXEC_R; ADD is a harmless fallback
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (op)
      OP_ADD:  alu_ctrl = ALU_ADD;
      OP_SUB:  alu_ctrl = ALU_SUB;
      OP_AND:  alu_ctrl = ALU_AND;
      OP_OR:   alu_ctrl = ALU_OR;
      OP_SLT:  alu_ctrl = ALU_SLT;
      OP_NOR:  alu_ctrl = ALU_NOR;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the NITC-RISC24 datapath.
//   clk     in  1     : rising-edge clock
//   reset   in  1     : asynchronous, active-low reset
//   bus     master    : Op/cz/Zero in, every datapath strobe out (see mc_if)
//   zflag   out 1     : architectural zero flag
//   halted  out 1     : high while in HALT
//   illegal out 1     : one-cycle pulse in DECODE on an undefined opcode
//   instret out CNT_W : retired-instruction count
// Macro MC_INSTRET_EN: when defined the instret counter is built, otherwise
// instret is tied to 0 and no counter flops exist.
module mc_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  mc_if.master             bus,
  output logic             zflag,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e     state_q, state_d;
  logic       zflag_q, zflag_d;
  logic       illegal_raw;
  logic [3:0] r_alu_ctrl;
  strobe_t    strb;
  strobe_t    strb_gated;

  mc_alu_decode u_alu_decode (
    .op       (bus.Op),
    .alu_ctrl (r_alu_ctrl)
  );

  // State and zero-flag registers; reset parks the FSM in FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zflag_q <= zflag_d;
    end
  end

  // Next-state decode and Moore strobes; only PCSel in BRANCH follows Zero
  always_comb begin
    state_d     = state_q;
    zflag_d     = zflag_q;
    illegal_raw = 1'b0;
    strb        = '0;

    case (state_q)
      ST_FETCH: begin
        strb.mem_read  = 1'b1;
        strb.ir_write  = 1'b1;
        strb.alu_src_b = SRCB_ONE;
        strb.alu_ctrl  = ALU_ADD;
        strb.pc_sel    = 1'b1;
        state_d        = ST_DECODE;
      end

      ST_DECODE: begin
        // PC + imm is computed here so BRANCH finds the target in ALUOut
        strb.alu_src_b = SRCB_IMM;
        strb.alu_ctrl  = ALU_ADD;
        if (is_rtype(bus.Op)) begin
          if (bus.cz == CZ_ALWAYS) begin
            state_d = ST_EXEC_R;
          end else if (bus.cz == CZ_IF_ZERO) begin
            state_d = zflag_q ? ST_EXEC_R : ST_FETCH;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          case (bus.Op)
            OP_ADI, OP_LW, OP_SW: state_d = ST_EXEC_I;
            OP_BEQ:               state_d = ST_BRANCH;
            OP_HALT:              state_d = ST_HALT;
            default: begin
              state_d     = ST_FETCH;
              illegal_raw = 1'b1;
            end
          endcase
        end
      end

      ST_EXEC_R: begin
        strb.alu_src_a = 1'b1;
        strb.alu_src_b = SRCB_REG;
        strb.alu_ctrl  = r_alu_ctrl;
        zflag_d        = bus.Zero;
        state_d        = ST_WB_R;
      end

      ST_WB_R: begin
        strb.reg_write = 1'b1;
        strb.reg_dst   = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_EXEC_I: begin
        // Address computations for LW/SW must not disturb the flag
        strb.alu_src_a = 1'b1;
        strb.alu_src_b = SRCB_IMM;
        strb.alu_ctrl  = ALU_ADD;
        case (bus.Op)
          OP_ADI: begin
            zflag_d = bus.Zero;
            state_d = ST_WB_I;
          end
          OP_LW:   state_d = ST_MEM_RD;
          OP_SW:   state_d = ST_MEM_WR;
          default: state_d = ST_FETCH;
        endcase
      end

      ST_WB_I: begin
        strb.reg_write = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_MEM_RD: begin
        strb.iord     = 1'b1;
        strb.mem_read = 1'b1;
        state_d       = ST_MEM_WB;
      end

      ST_MEM_WB: begin
        strb.reg_write  = 1'b1;
        strb.mem_to_reg = 1'b1;
        state_d         = ST_FETCH;
      end

      ST_MEM_WR: begin
        strb.iord      = 1'b1;
        strb.mem_write = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_BRANCH: begin
        strb.alu_src_a = 1'b1;
        strb.alu_src_b = SRCB_REG;
        strb.alu_ctrl  = ALU_SUB;
        strb.pc_source = 1'b1;
        strb.pc_sel    = bus.Zero;
        state_d        = ST_FETCH;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // While reset is low the FSM sits in FETCH, whose strobes are non-zero,
  // so every strobe is masked combinationally to keep the datapath quiet
  always_comb begin
    strb_gated = reset ? strb : '0;
  end

  assign bus.IorD     = strb_gated.iord;
  assign bus.MemRead  = strb_gated.mem_read;
  assign bus.MemWrite = strb_gated.mem_write;
  assign bus.MemtoReg = strb_gated.mem_to_reg;
  assign bus.IRWrite  = strb_gated.ir_write;
  assign bus.PCSource = strb_gated.pc_source;
  assign bus.ALUSrcA  = strb_gated.alu_src_a;
  assign bus.RegWrite = strb_gated.reg_write;
  assign bus.RegDst   = strb_gated.reg_dst;
  assign bus.PCSel    = strb_gated.pc_sel;
  assign bus.ALUSrcB  = strb_gated.alu_src_b;
  assign bus.ALUCtrl  = strb_gated.alu_ctrl;

  assign zflag   = zflag_q;
  assign halted  = reset & (state_q == ST_HALT);
  assign illegal = reset & illegal_raw;

`ifdef MC_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  // Every entry into FETCH retires one instruction, skipped or illegal included
  always_comb begin
    instret_d = instret_q;
    if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // Retired-instruction register, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed, scoreboard-checked bench for mc_control.
// Stimulus pushes the hand-derived expected output vector for each cycle;
// an independent monitor pops and compares on the falling edge (or on an
// explicit probe for the asynchronous reset check).
module tb_mc_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             zflag, halted, illegal;
  logic [CNT_W-1:0] instret;

  mc_if bus();

  mc_control #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .zflag   (zflag),
    .halted  (halted),
    .illegal (illegal),
    .instret (instret)
  );

  always #5 clk = ~clk;

  typedef enum int {T_RST, T_F, T_D, T_ER, T_WR, T_EI, T_WI, T_MRD, T_MWB, T_MWR, T_BR, T_H} tst_e;

  typedef struct {
    string       name;
    logic [22:0] v;
  } item_t;

  item_t            sb[$];
  int               n_vec  = 0;
  int               n_miss = 0;
  logic             zf_m = 1'b0;
  logic [CNT_W-1:0] cnt_m = '0;
  bit               from_reset = 1'b1;
  event             probe_ev;

  // Expected strobes, ordered {IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  // PCSource,ALUSrcA,RegWrite,RegDst,PCSel, ALUSrcB, ALUCtrl}
  function automatic logic [15:0] exp_strobes(tst_e t, logic [3:0] op, logic zero);
    logic [3:0] rc;
    case (op)
      4'd1:    rc = 4'b0010;
      4'd2:    rc = 4'b0110;
      4'd3:    rc = 4'b0000;
      4'd4:    rc = 4'b0001;
      4'd5:    rc = 4'b0111;
      4'd6:    rc = 4'b1100;
      default: rc = 4'b0010;
    endcase
    case (t)
      T_F:     return {10'b0100100001, 2'b01, 4'b0010};
      T_D:     return {10'b0000000000, 2'b10, 4'b0010};
      T_ER:    return {10'b0000001000, 2'b00, rc};
      T_WR:    return {10'b0000000110, 2'b00, 4'b0000};
      T_EI:    return {10'b0000001000, 2'b10, 4'b0010};
      T_WI:    return {10'b0000000100, 2'b00, 4'b0000};
      T_MRD:   return {10'b1100000000, 2'b00, 4'b0000};
      T_MWB:   return {10'b0001000100, 2'b00, 4'b0000};
      T_MWR:   return {10'b1010000000, 2'b00, 4'b0000};
      T_BR:    return {9'b000001100, zero, 2'b00, 4'b0110};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef MC_INSTRET_EN
    return cnt_m;
`else
    return '0;
`endif
  endfunction

  task automatic push(string name, logic [22:0] v);
    item_t it;
    it.name = name;
    it.v    = v;
    sb.push_back(it);
  endtask

  // One clock of stimulus: drive inputs just after the edge, queue expectation
  task automatic applyStimulus(string name, tst_e t, logic [3:0] op, logic [1:0] cz,
                               logic zero, logic ill);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    bus.Op   = op;
    bus.cz   = cz;
    bus.Zero = zero;
    if (t == T_F) begin
      if (!from_reset) cnt_m = cnt_m + 1'b1;
      from_reset = 1'b0;
    end
    push(name, {exp_strobes(t, op, zero), zf_m, (t == T_H), ill, exp_cnt()});
    if ((t == T_ER) || ((t == T_EI) && (op == 4'b0111))) zf_m = zero;
  endtask

  task automatic reset_model();
    zf_m       = 1'b0;
    cnt_m      = '0;
    from_reset = 1'b1;
  endtask

  task automatic do_reset(string name);
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    push({name, ".async"}, 23'h0);
    @(posedge clk);
    #1;
    push({name, ".hold"}, 23'h0);
  endtask

  // Full instruction; Zero is the real value only where the FSM samples it,
  // its complement everywhere else so stray sampling is exposed
  task automatic run_instr(string name, logic [15:0] instr, logic zero, int upto);
    logic [3:0] op;
    logic [1:0] cz;
    logic       ill;
    logic       nz;
    int         n;
    op  = instr[15:12];
    cz  = instr[1:0];
    nz  = ~zero;
    ill = !((op >= 4'd1 && op <= 4'd10) || op == 4'd15);
    n   = 0;
    applyStimulus({name, ".F"}, T_F, op, cz, nz, 1'b0);
    applyStimulus({name, ".D"}, T_D, op, cz, nz, ill);
    if (op >= 4'd1 && op <= 4'd6) begin
      if (cz == 2'b00 || (cz == 2'b01 && zf_m)) begin
        applyStimulus({name, ".ER"}, T_ER, op, cz, zero, 1'b0);
        if (upto != 3) applyStimulus({name, ".WR"}, T_WR, op, cz, nz, 1'b0);
      end
    end else begin
      case (op)
        4'd7: begin
          applyStimulus({name, ".EI"}, T_EI, op, cz, zero, 1'b0);
          applyStimulus({name, ".WI"}, T_WI, op, cz, nz, 1'b0);
        end
        4'd8: begin
          applyStimulus({name, ".EI"}, T_EI, op, cz, zero, 1'b0);
          applyStimulus({name, ".MRD"}, T_MRD, op, cz, nz, 1'b0);
          applyStimulus({name, ".MWB"}, T_MWB, op, cz, nz, 1'b0);
        end
        4'd9: begin
          applyStimulus({name, ".EI"}, T_EI, op, cz, zero, 1'b0);
          applyStimulus({name, ".MWR"}, T_MWR, op, cz, nz, 1'b0);
        end
        4'd10: applyStimulus({name, ".BR"}, T_BR, op, cz, zero, 1'b0);
        4'd15: begin
          while (n < 20) begin
            applyStimulus($sformatf("%s.H%0d", name, n), T_H, op, cz, n[0], 1'b0);
            n++;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Pull reset low in the middle of WB_R and check outputs drop at once
  task automatic mid_reset();
    run_instr("rst_mid_add", 16'h1298, 1'b1, 4);
    @(negedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    push("rst_mid.async", 23'h0);
    #1;
    ->probe_ev;
    @(posedge clk);
    #1;
    push("rst_mid.hold", 23'h0);
  endtask

  // Monitor: pops one expectation per falling edge / probe and compares
  task automatic checkOutput();
    item_t       it;
    logic [22:0] act;
    forever begin
      @(negedge clk or probe_ev);
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        act = {bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.IRWrite,
               bus.PCSource, bus.ALUSrcA, bus.RegWrite, bus.RegDst, bus.PCSel,
               bus.ALUSrcB, bus.ALUCtrl, zflag, halted, illegal, instret};
        n_vec++;
        if (act !== it.v) begin
          n_miss++;
          $display("[TB] FAIL %s: got %h expected %h", it.name, act, it.v);
        end
      end
    end
  endtask

  initial checkOutput();

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.Op   = 4'h0;
    bus.cz   = 2'b00;
    bus.Zero = 1'b0;

    do_reset("rst0");
    run_instr("add",     16'h1298, 1'b0, 4);
    run_instr("adz_skp", 16'h1299, 1'b1, 4);
    run_instr("sub_z",   16'h2290, 1'b1, 4);
    run_instr("adz_exe", 16'h1299, 1'b0, 4);
    run_instr("and_c10", 16'h3292, 1'b1, 4);
    run_instr("or_c11",  16'h4293, 1'b1, 4);
    run_instr("adi_z",   16'h7281, 1'b1, 4);
    run_instr("lw",      16'h8302, 1'b0, 4);
    run_instr("sw",      16'h9302, 1'b0, 4);
    run_instr("orz_exe", 16'h4291, 1'b1, 4);
    run_instr("beq_tk",  16'hA5FE, 1'b1, 4);
    run_instr("beq_nt",  16'hA5FE, 1'b0, 4);
    run_instr("slt",     16'h5290, 1'b0, 4);
    run_instr("nor",     16'h6290, 1'b1, 4);
    run_instr("ill_b",   16'hB000, 1'b0, 4);
    run_instr("ill_0",   16'h0000, 1'b1, 4);
    run_instr("ill_c",   16'hC000, 1'b0, 4);
    run_instr("ill_d",   16'hD000, 1'b1, 4);
    run_instr("ill_e",   16'hE000, 1'b0, 4);
    run_instr("adz_wrap", 16'h1299, 1'b0, 4);
    mid_reset();
    run_instr("add_post", 16'h1298, 1'b0, 4);
    run_instr("halt",     16'hF000, 1'b0, 4);
    do_reset("rst_halt");
    run_instr("add_last", 16'h1298, 1'b1, 4);

    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the NITC-RISC24 processor. It sits directly upstream of the multi-cycle datapath. It consumes the datapath's `Op`, `Zero` and `cz` and drives every datapath control strobe, one FSM state per clock. It also holds the architectural zero flag used by conditional R-type instructions and reports halt and illegal-opcode status.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Op` in 4: opcode, `Instruction[15:12]`.
- `cz` in 2: condition field, `Instruction[1:0]`.
- `Zero` in 1: datapath asserts this when the combinational `ALUResult == 0`.
- `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `PCSource`, `ALUSrcA`, `RegWrite`, `RegDst`, `PCSel` out 1 each: datapath strobes.
- `ALUSrcB` out 2: ALU B operand select. 00 selects B, 01 selects the constant 1, 1x selects the sign-extended imm6.
- `ALUCtrl` out 4: ALU operation code.
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- `zflag` out 1: architectural zero flag.
- `halted` out 1: high in the HALT state.
- `illegal` out 1: one-cycle pulse on an undefined opcode.
- `instret` out `CNT_W`: retired-instruction count.

## Operation
Opcodes:
- R-type: ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101, NOR 0110. Destination is rc.
- ADI 0111: rb <= ra + sext(imm6).
- LW 1000: rb <= mem[ra + imm].
- SW 1001: mem[ra + imm] <= rb.
- BEQ 1010: if ra == rb, PC <= PC + 1 + imm.
- HALT 1111.
- All other opcodes are illegal.

Outputs are Moore (decoded from the state), except `PCSel` in BRANCH, which follows `Zero`. Any strobe not listed for a state is 0.

States and transitions:
- FETCH: `MemRead`=1, `IorD`=0, `IRWrite`=1, `ALUSrcA`=0, `ALUSrcB`=01, `ALUCtrl`=ADD, `PCSel`=1, `PCSource`=0. Next state is DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=10, `ALUCtrl`=ADD, which precomputes the branch target into ALUOut. Next state by opcode:
  - R-type with cz=00 → EXEC_R.
  - R-type with cz=01 → EXEC_R if `zflag`=1, otherwise FETCH (skipped).
  - R-type with cz=1x → FETCH (skipped).
  - ADI, LW, SW → EXEC_I.
  - BEQ → BRANCH.
  - HALT → HALT.
  - Illegal → FETCH, with `illegal`=1 for that cycle.
- EXEC_R: `ALUSrcA`=1, `ALUSrcB`=00, `ALUCtrl` per opcode; `zflag` <= `Zero`. Next state is WB_R.
- WB_R: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Next state is FETCH.
- EXEC_I: `ALUSrcA`=1, `ALUSrcB`=10, `ALUCtrl`=ADD. `zflag` <= `Zero` for ADI only. Next state by opcode:
  - ADI → WB_I.
  - LW → MEM_RD.
  - SW → MEM_WR.
- WB_I: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Next state is FETCH.
- MEM_RD: `IorD`=1, `MemRead`=1. Next state is MEM_WB.
- MEM_WB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=1. Next state is FETCH.
- MEM_WR: `IorD`=1, `MemWrite`=1. Next state is FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUCtrl`=SUB, `PCSource`=1, `PCSel`=`Zero`. Next state is FETCH.
- HALT: all strobes 0, `halted`=1. The FSM stays in HALT until reset.

Counter rules:
- `instret` increments by 1 on every transition into FETCH from any state except reset, including skipped instructions and illegal opcodes.
- `instret` wraps modulo 2^`CNT_W`.

## Timing
- Reset asserted (low), immediately and asynchronously:
  - state = FETCH;
  - every output = 0, including `zflag`, `halted`, `illegal` and `instret`;
  - strobes are forced to 0 for as long as `reset` is low.
- First rising edge after reset release: the FETCH strobes are active.
- Latency in cycles: R-type 4, ADI 4, LW 5, SW 4, BEQ 3, skipped or illegal 2, HALT is terminal.
- Reset asserted mid-instruction aborts it; no partial write is issued after reset asserts.
- `Zero` is sampled only in EXEC_R, EXEC_I (ADI) and BRANCH.

## Configuration
- `MC_INSTRET_EN` defined: the `instret` counter is implemented as specified.
- `MC_INSTRET_EN` undefined: no counter flops are implemented and `instret` is tied to 0. All other behaviour is unchanged.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - the opcode constants;
  - the ALUCtrl constants;
  - the cz encodings.
- Sub-module `mc_alu_decode`: combinational mapping from opcode to `ALUCtrl` for EXEC_R.

## Test plan
- Reset mid-operation: pull `reset` low during WB_R → `RegWrite` and all other outputs drop to 0 without waiting for a clock. After release, the first cycle shows `IRWrite`=1, `MemRead`=1, `PCSel`=1, and `instret`=0.
- ADD 0x1298 with r1=1, r2=7:
  - states are FETCH, DECODE, EXEC_R, WB_R;
  - EXEC_R shows `ALUCtrl`=0010, `ALUSrcB`=00;
  - WB_R shows `RegWrite`=1, `RegDst`=1;
  - result r3=8, `zflag`=0, `instret`+1.
- Conditional skip: 0x1299 (ADZ) with `zflag`=0 → FETCH, DECODE, FETCH; `RegWrite` never asserts; `instret`+1.
- LW 0x8302: 5 cycles; MEM_RD shows `IorD`=1, `MemRead`=1; MEM_WB shows `RegWrite`=1, `RegDst`=0, `MemtoReg`=1; r4 = mem[3].
- BEQ 0xA5FE at PC=4 with r2=r7=7:
  - BRANCH shows `PCSel`=1, `PCSource`=1, and the PC becomes 3;
  - repeat with r7=6 → `PCSel`=0 and the PC stays at 5.
- Illegal 0xB000 → `illegal` high for exactly 1 cycle, then FETCH.
- HALT 0xF000 → `halted`=1 and all strobes stay 0 for 20 cycles, until reset.
